// File: rtl/motor_pkg.sv
// rtl/motor_pkg.sv - shared types, default timing and helpers for the motor command scheduler
package motor_pkg;

  typedef enum logic [1:0] {STOP = 2'd0, FWD = 2'd1, BACK = 2'd2, TURN = 2'd3} motor_cmd_t;
  typedef enum logic [1:0] {IDLE = 2'd0, HOLD = 2'd1, SEND = 2'd2, GAP = 2'd3} sched_state_t;

  localparam int unsigned DEF_STABLE_CYCLES    = 50_000;
  localparam int unsigned DEF_HEARTBEAT_CYCLES = 25_000_000;
  localparam int unsigned DEF_HOLD_CYCLES      = 4;
  localparam int unsigned DEF_ARM_CYCLES       = 16;
  localparam int unsigned DEF_TIMEOUT_CYCLES   = 200_000;
  localparam int unsigned DEF_GAP_CYCLES       = 5_000;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // Only the selected sender leaves reset; every other bit stays high.
  function automatic logic [3:0] release_mask(input motor_cmd_t cmd);
    logic [3:0] m;
    m      = 4'b1111;
    m[cmd] = 1'b0;
    return m;
  endfunction

endpackage

// File: rtl/input_debouncer.sv
// rtl/input_debouncer.sv - accepts a value once it has held still for STABLE_CYCLES cycles
module input_debouncer #(
  parameter int unsigned WIDTH         = 5,
  parameter int unsigned STABLE_CYCLES = 50_000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             chg_o
);

  localparam int unsigned CW = $clog2(STABLE_CYCLES + 1);

  logic [WIDTH-1:0] last_q;
  logic [CW-1:0]    cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= '0;
      cnt_q  <= '0;
      dout_o <= '0;
      chg_o  <= 1'b0;
    end else begin
      chg_o <= 1'b0;
      if (din_i != last_q) begin
        last_q <= din_i;
        cnt_q  <= '0;
      end else if (cnt_q == CW'(STABLE_CYCLES - 1)) begin
        // Saturate at STABLE_CYCLES so a held value is latched exactly once.
        cnt_q  <= CW'(STABLE_CYCLES);
        dout_o <= din_i;
        chg_o  <= (din_i != dout_o);
      end else if (cnt_q != CW'(STABLE_CYCLES)) begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

endmodule

// File: rtl/motor_cmd_scheduler.sv
// rtl/motor_cmd_scheduler.sv - releases one UART frame sender at a time on command change or heartbeat
module motor_cmd_scheduler
  import motor_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES    = DEF_STABLE_CYCLES,
  parameter int unsigned HEARTBEAT_CYCLES = DEF_HEARTBEAT_CYCLES,
  parameter int unsigned HOLD_CYCLES      = DEF_HOLD_CYCLES,
  parameter int unsigned ARM_CYCLES       = DEF_ARM_CYCLES,
  parameter int unsigned TIMEOUT_CYCLES   = DEF_TIMEOUT_CYCLES,
  parameter int unsigned GAP_CYCLES       = DEF_GAP_CYCLES
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] cmd_req,
  input  logic [2:0] speed_in,
  input  logic [3:0] sender_ready,
  output logic [3:0] sender_rst,
  output logic [2:0] speed_out,
  output logic [1:0] active_cmd,
  output logic       busy,
  output logic       frame_done,
  output logic       err_timeout,
  output logic [7:0] timeout_cnt
);

  localparam int unsigned CNT_MAX = max_u(max_u(HEARTBEAT_CYCLES, TIMEOUT_CYCLES),
                                          max_u(max_u(HOLD_CYCLES, GAP_CYCLES), ARM_CYCLES));
  localparam int unsigned CW = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] HB_LAST   = CW'(HEARTBEAT_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST   = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);
  localparam logic [CW-1:0] ARM_C     = CW'(ARM_CYCLES);

  sched_state_t  state_q;
  logic [CW-1:0] cnt_q;
  logic          pending_q;
  logic [4:0]    sent_q;
  logic [4:0]    acc_pair;
  logic          acc_chg;
  logic          new_req;
  logic          ready_hit;

  input_debouncer #(
    .WIDTH         (5),
    .STABLE_CYCLES (STABLE_CYCLES)
  ) u_debouncer (
    .clk    (clk),
    .rst_n  (rst),
    .din_i  ({cmd_req, speed_in}),
    .dout_o (acc_pair),
    .chg_o  (acc_chg)
  );

  assign new_req   = acc_chg && (acc_pair != sent_q);
  assign ready_hit = sender_ready[active_cmd] && (cnt_q >= ARM_C);

  // cnt_q is shared: heartbeat in IDLE, dwell time in HOLD/SEND/GAP.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      pending_q   <= 1'b1;
      sent_q      <= '0;
      sender_rst  <= 4'b1111;
      speed_out   <= '0;
      active_cmd  <= STOP;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      err_timeout <= 1'b0;
      timeout_cnt <= '0;
    end else begin
      frame_done <= 1'b0;
      cnt_q      <= cnt_q + CW'(1);
      pending_q  <= pending_q | new_req;
      case (state_q)
        IDLE: begin
          if (pending_q || new_req) begin
            state_q                 <= HOLD;
            cnt_q                   <= '0;
            pending_q               <= 1'b0;
            {active_cmd, speed_out} <= acc_pair;
            sent_q                  <= acc_pair;
            busy                    <= 1'b1;
          end else if (cnt_q == HB_LAST) begin
            pending_q <= 1'b1;
          end
        end
        HOLD: begin
          if (cnt_q == HOLD_LAST) begin
            state_q    <= SEND;
            cnt_q      <= '0;
            sender_rst <= release_mask(motor_cmd_t'(active_cmd));
          end
        end
        SEND: begin
          if (ready_hit || (cnt_q == TO_LAST)) begin
            state_q    <= GAP;
            cnt_q      <= '0;
            sender_rst <= 4'b1111;
            if (ready_hit) begin
              frame_done <= 1'b1;
            end else begin
              err_timeout <= 1'b1;
              if (timeout_cnt != 8'hFF) timeout_cnt <= timeout_cnt + 8'd1;
            end
          end
        end
        GAP: begin
          if (cnt_q == GAP_LAST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy    <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_motor_cmd_scheduler.sv
// tb/tb_motor_cmd_scheduler.sv - randomized self-checking bench for motor_cmd_scheduler
module tb_motor_cmd_scheduler;

  localparam int STABLE = 4;
  localparam int HB     = 100;
  localparam int HOLD   = 2;
  localparam int ARM    = 3;
  localparam int TMO    = 20;
  localparam int GAP    = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] cmd_req = 2'd0;
  logic [2:0] speed_in = 3'd0;
  logic [3:0] sender_ready = 4'd0;
  logic [3:0] sender_rst;
  logic [2:0] speed_out;
  logic [1:0] active_cmd;
  logic       busy;
  logic       frame_done;
  logic       err_timeout;
  logic [7:0] timeout_cnt;

  int checks = 0;
  int failures = 0;

  int         m_tmo = 0;
  bit         m_err = 1'b0;
  logic [4:0] m_sent = 5'd0;

  bit         o_started, o_ok;
  int         o_wait, o_hold, o_send, o_gap, o_dones;
  logic [3:0] o_mask;
  logic [1:0] o_cmd;
  logic [2:0] o_spd;

  localparam logic [19:0] RESET_VEC = {4'hF, 3'd0, 2'd0, 1'b0, 1'b0, 1'b0, 8'd0};

  always #5 clk = ~clk;

  motor_cmd_scheduler #(
    .STABLE_CYCLES    (STABLE),
    .HEARTBEAT_CYCLES (HB),
    .HOLD_CYCLES      (HOLD),
    .ARM_CYCLES       (ARM),
    .TIMEOUT_CYCLES   (TMO),
    .GAP_CYCLES       (GAP)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_req      (cmd_req),
    .speed_in     (speed_in),
    .sender_ready (sender_ready),
    .sender_rst   (sender_rst),
    .speed_out    (speed_out),
    .active_cmd   (active_cmd),
    .busy         (busy),
    .frame_done   (frame_done),
    .err_timeout  (err_timeout),
    .timeout_cnt  (timeout_cnt)
  );

  initial begin
    #500000;
    $display("FAIL global_timeout simulation exceeded time limit");
    $fatal(1);
  end

  // Reference: a sender with one low bit, the one named by the command.
  function automatic logic [3:0] exp_mask(input logic [1:0] cmd);
    return 4'hF ^ (4'd1 << cmd);
  endfunction

  // Reference outcome of one SEND window: ready before ARM is ignored, ready wins a tie with timeout.
  task automatic model_frame(input int ready_at, input bit hold, output int len, output bit done);
    int eff;
    if (ready_at < 0)                eff = TMO;
    else if (hold && ready_at < ARM) eff = ARM;
    else if (ready_at < ARM)         eff = TMO;
    else                             eff = ready_at;
    done = (eff < TMO);
    len  = done ? eff + 1 : TMO;
  endtask

  // Drives the sender side of one frame and records what the DUT did.
  task automatic observe_frame(input int ready_at, input bit ready_hold, input int budget);
    int c;
    o_started = 1'b0; o_ok = 1'b1; o_wait = 0; o_hold = 0; o_send = 0; o_gap = 0; o_dones = 0;
    o_mask = 4'hF; o_cmd = 2'd0; o_spd = 3'd0;
    while (o_wait < budget) begin
      @(negedge clk);
      if (busy) begin o_started = 1'b1; break; end
      o_wait++;
    end
    if (!o_started) return;
    o_cmd = active_cmd;
    o_spd = speed_out;
    while (busy && sender_rst == 4'hF && o_hold < 1000) begin
      if (frame_done || speed_out != o_spd) o_ok = 1'b0;
      o_hold++;
      @(negedge clk);
    end
    o_mask = sender_rst;
    c = 0;
    while (sender_rst != 4'hF && c < 1000) begin
      if (frame_done) o_dones++;
      if (sender_rst != o_mask || active_cmd != o_cmd || speed_out != o_spd) o_ok = 1'b0;
      sender_ready = (4'($urandom) & o_mask) |
                     (((c == ready_at) || (ready_hold && ready_at >= 0 && c >= ready_at)) ? ~o_mask : 4'h0);
      c++;
      @(negedge clk);
    end
    o_send = c;
    sender_ready = 4'h0;
    while (busy && o_gap < 1000) begin
      if (frame_done) o_dones++;
      if (sender_rst != 4'hF || speed_out != o_spd) o_ok = 1'b0;
      o_gap++;
      @(negedge clk);
    end
  endtask

  task automatic drive_pair(input logic [4:0] p);
    {cmd_req, speed_in} = p;
  endtask

  function automatic logic [4:0] fresh_pair();
    logic [4:0] p;
    p = 5'($urandom);
    if (p == m_sent) p[0] = ~p[0];
    return p;
  endfunction

  task automatic test_reset;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({sender_rst, speed_out, active_cmd, busy, frame_done, err_timeout, timeout_cnt} !== RESET_VEC) begin
      failures++;
      $display("FAIL reset_outputs got=%h exp=%h",
               {sender_rst, speed_out, active_cmd, busy, frame_done, err_timeout, timeout_cnt}, RESET_VEC);
    end
  endtask

  task automatic test_first_stop;
    int e_len; bit e_done;
    rst = 1'b1;
    observe_frame(6, 1'b0, 10);
    model_frame(6, 1'b0, e_len, e_done);
    checks++; if (!o_started) begin failures++; $display("FAIL first_started got=0 exp=1"); end
    checks++; if (o_mask !== 4'b1110) begin failures++; $display("FAIL first_mask got=%b exp=1110", o_mask); end
    checks++; if ({o_cmd, o_spd} !== 5'd0) begin failures++; $display("FAIL first_pair got=%h exp=0", {o_cmd, o_spd}); end
    checks++; if (o_hold != HOLD) begin failures++; $display("FAIL first_hold got=%0d exp=%0d", o_hold, HOLD); end
    checks++; if (o_send != e_len) begin failures++; $display("FAIL first_send_len got=%0d exp=%0d", o_send, e_len); end
    checks++; if (o_dones != 1) begin failures++; $display("FAIL first_done_count got=%0d exp=1", o_dones); end
    checks++; if (o_gap != GAP) begin failures++; $display("FAIL first_gap got=%0d exp=%0d", o_gap, GAP); end
    checks++; if (!o_ok) begin failures++; $display("FAIL first_stable got=0 exp=1"); end
  endtask

  task automatic test_change;
    drive_pair({2'd2, 3'd3});
    observe_frame(8, 1'b0, 30);
    m_sent = {2'd2, 3'd3};
    checks++; if (!o_started) begin failures++; $display("FAIL change_started got=0 exp=1"); end
    checks++;
    if (o_wait < STABLE || o_wait > STABLE + 2) begin
      failures++; $display("FAIL change_debounce_wait got=%0d exp=%0d..%0d", o_wait, STABLE, STABLE + 2);
    end
    checks++; if (o_mask !== 4'b1011) begin failures++; $display("FAIL change_mask got=%b exp=1011", o_mask); end
    checks++; if ({o_cmd, o_spd} !== m_sent) begin failures++; $display("FAIL change_pair got=%h exp=%h", {o_cmd, o_spd}, m_sent); end
    checks++; if (o_send != 9 || o_dones != 1) begin failures++; $display("FAIL change_done got=len%0d/done%0d exp=len9/done1", o_send, o_dones); end
  endtask

  task automatic test_toggle;
    int busy_cycles;
    int r;
    int e_len; bit e_done;
    busy_cycles = 0;
    for (int i = 0; i < 10; i++) begin
      drive_pair({(i % 2 == 0) ? 2'd1 : 2'd2, 3'd5});
      repeat (2) begin @(negedge clk); if (busy) busy_cycles++; end
    end
    checks++; if (busy_cycles != 0) begin failures++; $display("FAIL toggle_quiet got=%0d exp=0", busy_cycles); end
    drive_pair({2'd1, 3'd5});
    r = int'($urandom_range(0, TMO - 1));
    observe_frame(r, 1'b1, 30);
    model_frame(r, 1'b1, e_len, e_done);
    m_sent = {2'd1, 3'd5};
    checks++; if ({o_cmd, o_spd} !== m_sent || o_mask !== 4'b1101) begin
      failures++; $display("FAIL toggle_pair got=%h/%b exp=%h/1101", {o_cmd, o_spd}, o_mask, m_sent);
    end
    checks++; if (o_send != e_len || o_dones != 1) begin
      failures++; $display("FAIL toggle_done got=len%0d/done%0d exp=len%0d/done1", o_send, o_dones, e_len);
    end
    busy_cycles = 0;
    repeat (30) begin @(negedge clk); if (busy) busy_cycles++; end
    checks++; if (busy_cycles != 0) begin failures++; $display("FAIL toggle_single_frame got=%0d exp=0", busy_cycles); end
  endtask

  // Boundaries of the arming window and the watchdog, then random frames, all against model_frame.
  task automatic test_arm_and_timeout(input int n_random);
    int ra[5] = '{-1, ARM - 1, ARM, 0, TMO - 1};
    bit rh[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    int r; bit h; int e_len; bit e_done; logic [4:0] p;
    for (int i = 0; i < 5 + n_random; i++) begin
      if (i < 5) begin
        r = ra[i]; h = rh[i];
      end else begin
        r = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, TMO + 2));
        h = 1'($urandom);
        drive_pair(5'($urandom));
        repeat (int'($urandom_range(1, STABLE - 1))) @(negedge clk);
      end
      p = fresh_pair();
      drive_pair(p);
      observe_frame(r, h, 40);
      model_frame(r, h, e_len, e_done);
      m_sent = p;
      if (!e_done) begin m_err = 1'b1; m_tmo = (m_tmo < 255) ? m_tmo + 1 : 255; end
      checks++; if (!o_started || {o_cmd, o_spd} !== p || o_mask !== exp_mask(p[4:3])) begin
        failures++; $display("FAIL frame%0d_select got=%0d/%h/%b exp=1/%h/%b", i, o_started, {o_cmd, o_spd}, o_mask, p, exp_mask(p[4:3]));
      end
      checks++; if (o_send != e_len) begin failures++; $display("FAIL frame%0d_send_len ready_at=%0d hold=%0d got=%0d exp=%0d", i, r, h, o_send, e_len); end
      checks++; if (o_dones != int'(e_done)) begin failures++; $display("FAIL frame%0d_done_count got=%0d exp=%0d", i, o_dones, e_done); end
      checks++; if (err_timeout !== m_err || timeout_cnt !== 8'(m_tmo)) begin
        failures++; $display("FAIL frame%0d_timeout_flags got=%0d/%0d exp=%0d/%0d", i, err_timeout, timeout_cnt, m_err, m_tmo);
      end
      checks++; if (o_gap != GAP || o_hold != HOLD || !o_ok) begin
        failures++; $display("FAIL frame%0d_timing got=hold%0d/gap%0d/ok%0d exp=hold%0d/gap%0d/ok1", i, o_hold, o_gap, o_ok, HOLD, GAP);
      end
    end
  endtask

  task automatic test_heartbeat;
    observe_frame(5, 1'b0, HB + 20);
    checks++; if (!o_started) begin failures++; $display("FAIL heartbeat_started got=0 exp=1"); end
    checks++; if (o_wait < HB - 1 || o_wait > HB + 1) begin
      failures++; $display("FAIL heartbeat_idle got=%0d exp=%0d..%0d", o_wait, HB - 1, HB + 1);
    end
    checks++; if ({o_cmd, o_spd} !== m_sent || o_dones != 1) begin
      failures++; $display("FAIL heartbeat_pair got=%h/done%0d exp=%h/done1", {o_cmd, o_spd}, o_dones, m_sent);
    end
  endtask

  task automatic test_async_reset;
    int n;
    logic [4:0] p;
    p = {2'd3, 3'($urandom_range(1, 7))};
    if (p == m_sent) p[2:0] = p[2:0] ^ 3'd1;
    drive_pair(p);
    n = 0;
    while (sender_rst == 4'hF && n < 40) begin @(negedge clk); n++; end
    checks++; if (sender_rst !== exp_mask(2'd3)) begin failures++; $display("FAIL areset_in_send got=%b exp=%b", sender_rst, exp_mask(2'd3)); end
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({sender_rst, speed_out, active_cmd, busy, frame_done, err_timeout, timeout_cnt} !== RESET_VEC) begin
      failures++;
      $display("FAIL areset_outputs got=%h exp=%h",
               {sender_rst, speed_out, active_cmd, busy, frame_done, err_timeout, timeout_cnt}, RESET_VEC);
    end
    @(negedge clk);
    rst = 1'b1;
    m_sent = 5'd0; m_err = 1'b0; m_tmo = 0;
    observe_frame(4, 1'b0, 10);
    checks++; if ({o_cmd, o_spd} !== 5'd0 || o_dones != 1 || err_timeout !== 1'b0) begin
      failures++; $display("FAIL areset_stop_frame got=%h/done%0d/err%0d exp=0/done1/err0", {o_cmd, o_spd}, o_dones, err_timeout);
    end
    observe_frame(4, 1'b0, 30);
    checks++; if ({o_cmd, o_spd} !== p || o_dones != 1) begin
      failures++; $display("FAIL areset_pending_frame got=%h/done%0d exp=%h/done1", {o_cmd, o_spd}, o_dones, p);
    end
  endtask

  initial begin
    test_reset();
    test_first_stop();
    test_change();
    test_toggle();
    test_arm_and_timeout(8);
    test_heartbeat();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
